// File: rtl/conv_17_19_acc_sat.sv
// Accumulates KERNEL_LEN signed products onto a per-window bias, then rounds,
// shifts and saturates the sum to a signed OUT_WIDTH result on a valid/ready stream.
module conv_17_19_acc_sat #(
  parameter int PROD_WIDTH = 24,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int KERNEL_LEN = 9,
  parameter int SHIFT      = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [PROD_WIDTH-1:0] prod_tdata,
  input  logic                  prod_tvalid,
  output logic                  prod_tready,
  input  logic [ACC_WIDTH-1:0]  bias,
  output logic [OUT_WIDTH-1:0]  out_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  out_sat
);

  localparam int CNT_W = $clog2(KERNEL_LEN);

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Rounding and clip bounds live in the ACC_WIDTH+1 domain so acc + half never wraps.
  localparam logic signed [ACC_WIDTH:0] C_HALF =
    {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] C_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] C_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [1:0]                  r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic [ACC_WIDTH-1:0]        r_acc;
  logic [OUT_WIDTH-1:0]        r_out_tdata;
  logic                        r_out_tvalid;
  logic                        r_out_sat;

  logic                        w_hs;
  logic [ACC_WIDTH-1:0]        w_prod_ext;
  logic [ACC_WIDTH-1:0]        w_base;
  logic signed [ACC_WIDTH:0]   w_rnd;
  logic signed [ACC_WIDTH:0]   w_shr;

  assign prod_tready = (r_state == ST_ACCUM);
  assign w_hs        = prod_tvalid & prod_tready;
  assign w_prod_ext  = {{(ACC_WIDTH-PROD_WIDTH){prod_tdata[PROD_WIDTH-1]}}, prod_tdata};
  assign w_base      = (r_cnt == '0) ? bias : r_acc;
  assign w_rnd       = $signed({r_acc[ACC_WIDTH-1], r_acc}) + C_HALF;
  assign w_shr       = w_rnd >>> SHIFT;

  assign out_tdata  = r_out_tdata;
  assign out_tvalid = r_out_tvalid;
  assign out_sat    = r_out_sat;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state      <= ST_ACCUM;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_out_tdata  <= '0;
      r_out_tvalid <= 1'b0;
      r_out_sat    <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_hs) begin
            r_acc <= w_base + w_prod_ext;
            if (r_cnt == CNT_W'(KERNEL_LEN - 1)) begin
              r_cnt   <= '0;
              r_state <= ST_REQ;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (w_shr > C_MAX) begin
            r_out_tdata <= {1'b0, {(OUT_WIDTH-1){1'b1}}};
            r_out_sat   <= 1'b1;
          end else if (w_shr < C_MIN) begin
            r_out_tdata <= {1'b1, {(OUT_WIDTH-1){1'b0}}};
            r_out_sat   <= 1'b1;
          end else begin
            r_out_tdata <= w_shr[OUT_WIDTH-1:0];
            r_out_sat   <= 1'b0;
          end
          r_out_tvalid <= 1'b1;
          r_state      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_out_tvalid && out_tready) begin
            r_out_tvalid <= 1'b0;
            r_state      <= ST_ACCUM;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

endmodule
